mac_array_ctrl: RTL
===================

Name: mac_array_ctrl

Overview:
Sequencer for the reconfigurable OS/WS MAC array. It accepts one job per start pulse and steps through the phases for the selected dataflow: WS kernel load, execute, drain; or OS execute, drain, flush. It emits the 3-bit per-row instruction bus {os, execute, kflush}, skewed one cycle per row. It sits between the top-level core FSM and the array's west instruction inputs, and also drives the input-buffer read strobe.

Parameters:
row, 8, number of array rows (instruction lanes)
col, 8, number of array columns
len_bw, 8, width of the execute-length field

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
start  input  1  job request; sampled only in IDLE
mode  input  1  0 = WS, 1 = OS; latched on accepted start
len  input  len_bw  number of execute cycles; latched on accepted start
inst_w  output  3*row  row r instruction at bits [3r+2:3r]: {os, execute, kflush}
l0_rd  output  1  input-buffer read strobe; one vector per asserted cycle
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse on job completion
phase  output  3  current state encoding (debug)

Behaviour:
- Clocking: one clock domain (clk). Reset is synchronous, active-high; all registers clear on reset.
- Reset values: inst_w=0, l0_rd=0, busy=0, done=0, phase=IDLE(0). Reset mid-job aborts immediately: next cycle is IDLE, all skew stages are 0, and no done pulse is produced.
- States and encodings: IDLE=0, KLOAD=1, EXEC=2, DRAIN=3, FLUSH=4, DONE=5. One down-counter cnt (width covers max(len, row+col)) times every phase.
- Start acceptance:
  - start=1 in IDLE with len!=0 is accepted.
  - start=1 in IDLE with len==0 is ignored; state stays IDLE and busy stays 0.
  - start in any other state is ignored.
- Registered base instruction `base`, by state:
  - IDLE: 000
  - KLOAD: 001
  - EXEC, WS: 010
  - EXEC, OS: 110
  - DRAIN, WS: 000
  - DRAIN, OS: 100
  - FLUSH: 101
  - DONE: os bit only
- Skew: inst_w row 0 = base. Row r = base delayed r cycles through a shift chain that always shifts, so the trailing rows keep emptying after the state returns to IDLE.
- Timing: start accepted at edge t. The first phase state, its base value and l0_rd are all visible after edge t+1 (registered outputs, one-cycle latency).
- WS sequence: KLOAD for col cycles (l0_rd=1) -> EXEC for len cycles (l0_rd=1) -> DRAIN for row+col cycles (l0_rd=0) -> DONE for 1 cycle (done=1) -> IDLE.
- OS sequence: EXEC for len cycles (l0_rd=1) -> DRAIN for row+col-1 cycles -> FLUSH for row cycles -> DONE for 1 cycle -> IDLE.
- l0_rd is asserted only in KLOAD and EXEC, so the total strobe count per job is exactly col+len (WS) or len (OS).
- Back-to-back jobs: start can be accepted in the IDLE cycle immediately after DONE.
- Counter reload: cnt is loaded with (phase length - 1) on entry to each phase; the phase exits when cnt==0.
- len=all-ones (255) must run exactly 255 EXEC cycles, with no wrap.

Optional Feature:
CTRL_PERF_EN:
- Defined: adds output perf_cycles [31:0] = number of busy cycles of the most recently completed job.
  - It is updated in the DONE cycle and counts from first busy cycle through DONE inclusive.
  - It saturates at 0xFFFFFFFF.
  - It is cleared by reset.
  - An aborted job does not update it.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- WS, row=col=8, len=4: start at cycle 0 -> KLOAD cycles 1-8 (row0 inst=001, l0_rd=1); EXEC cycles 9-12 (010); DRAIN cycles 13-28; done=1 at cycle 29; 12 l0_rd strobes total; perf_cycles=29.
- OS, len=3: start -> EXEC 3 cycles (110); DRAIN 15 cycles (100); FLUSH 8 cycles (101); done pulse; row 7 shows 110 starting 7 cycles after row 0.
- start with len=0 in IDLE -> busy stays 0, no done, inst_w stays 0.
- start pulsed during EXEC with mode toggled -> ignored; the job completes in its original mode with unchanged timing.
- reset asserted during DRAIN -> next cycle: phase=0, busy=0, inst_w all 0, no done; a new start is then accepted normally.
- Two back-to-back WS jobs (len=1, start held high) -> second KLOAD begins 2 cycles after the first done; exactly 2 done pulses.

Source files
------------

// File: rtl/mac_array_ctrl.sv
// -----------------------------------------------------------------------------
// mac_array_ctrl
//
// Job sequencer for the reconfigurable OS/WS MAC array. One job is accepted per
// start pulse (IDLE only, len != 0) and walked through its dataflow phases:
//   WS : KLOAD (col) -> EXEC (len) -> DRAIN (row+col)     -> DONE (1) -> IDLE
//   OS : EXEC (len)  -> DRAIN (row+col-1) -> FLUSH (row)  -> DONE (1) -> IDLE
// The 3-bit per-row instruction {os, execute, kflush} is skewed one cycle per
// row through a free-running shift chain.
//
// All outputs are registered from the current state, so they trail the
// internal state by one cycle.
//
// Optional feature macro: CTRL_PERF_EN
//   When defined, adds perf_cycles = busy cycles of the last completed job
//   (first busy cycle through DONE inclusive, saturating, cleared by reset).
//
// Ports:
//   clk         in   clock
//   reset       in   synchronous active-high reset
//   start       in   job request, sampled only in IDLE
//   mode        in   0 = WS, 1 = OS, latched on accepted start
//   len         in   execute cycle count, latched on accepted start
//   inst_w      out  row r instruction at [3r+2:3r] = {os, execute, kflush}
//   l0_rd       out  input-buffer read strobe (KLOAD and EXEC)
//   busy        out  high in every state except IDLE
//   done        out  one-cycle pulse on job completion
//   phase       out  current state encoding (debug)
//   perf_cycles out  (CTRL_PERF_EN only) busy cycles of last completed job
// -----------------------------------------------------------------------------
module mac_array_ctrl #(
  parameter int row    = 8,
  parameter int col    = 8,
  parameter int len_bw = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                mode,
  input  logic [len_bw-1:0]   len,
  output logic [3*row-1:0]    inst_w,
  output logic                l0_rd,
  output logic                busy,
  output logic                done,
  output logic [2:0]          phase
`ifdef CTRL_PERF_EN
  ,
  output logic [31:0]         perf_cycles
`endif
);

  // Counter must hold len-1 and row+col-1.
  localparam int SUM_W = $clog2(row + col);
  localparam int CNT_W = (len_bw > SUM_W) ? len_bw : SUM_W;

  localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [len_bw-1:0] LEN_ZERO = {len_bw{1'b0}};

  // Reload values are (phase length - 1); modular arithmetic keeps
  // row+col == 2**CNT_W correct.
  localparam logic [CNT_W-1:0] KLOAD_LAST    = CNT_W'(col) - CNT_ONE;
  localparam logic [CNT_W-1:0] WS_DRAIN_LAST = CNT_W'(row + col) - CNT_ONE;
  localparam logic [CNT_W-1:0] OS_DRAIN_LAST = CNT_W'(row + col) - CNT_ONE - CNT_ONE;
  localparam logic [CNT_W-1:0] FLUSH_LAST    = CNT_W'(row) - CNT_ONE;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_KLOAD = 3'd1,
    S_EXEC  = 3'd2,
    S_DRAIN = 3'd3,
    S_FLUSH = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic                mode_q,  mode_d;
  logic [len_bw-1:0]   len_q,   len_d;
  logic [CNT_W-1:0]    cnt_q,   cnt_d;

  logic [2:0]          phase_q, phase_d;
  logic                busy_q,  busy_d;
  logic                done_q,  done_d;
  logic                l0_rd_q, l0_rd_d;
  logic [2:0]          base_d;
  logic [3*row-1:0]    inst_q,  inst_d;

  // Next-state, latched job parameters and phase counter.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start && (len != LEN_ZERO)) begin
          mode_d = mode;
          len_d  = len;
          if (mode) begin
            state_d = S_EXEC;
            cnt_d   = CNT_W'(len) - CNT_ONE;
          end else begin
            state_d = S_KLOAD;
            cnt_d   = KLOAD_LAST;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_KLOAD: begin
        if (cnt_q == CNT_ZERO) begin
          state_d = S_EXEC;
          cnt_d   = CNT_W'(len_q) - CNT_ONE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_EXEC: begin
        if (cnt_q == CNT_ZERO) begin
          state_d = S_DRAIN;
          cnt_d   = mode_q ? OS_DRAIN_LAST : WS_DRAIN_LAST;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_DRAIN: begin
        if (cnt_q == CNT_ZERO) begin
          if (mode_q) begin
            state_d = S_FLUSH;
            cnt_d   = FLUSH_LAST;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_FLUSH: begin
        if (cnt_q == CNT_ZERO) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // Output decode from the current state; registered below.
  always_comb begin
    base_d = 3'b000;
    case (state_q)
      S_IDLE:  base_d = 3'b000;
      S_KLOAD: base_d = 3'b001;
      S_EXEC:  base_d = mode_q ? 3'b110 : 3'b010;
      S_DRAIN: base_d = mode_q ? 3'b100 : 3'b000;
      S_FLUSH: base_d = 3'b101;
      S_DONE:  base_d = {mode_q, 2'b00};
      default: base_d = 3'b000;
    endcase
    phase_d = state_q;
    busy_d  = (state_q != S_IDLE);
    done_d  = (state_q == S_DONE);
    l0_rd_d = (state_q == S_KLOAD) || (state_q == S_EXEC);
    // Row 0 takes the new base; every other row takes its upper neighbour.
    inst_d  = {inst_q[3*row-4:0], base_d};
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      mode_q  <= 1'b0;
      len_q   <= LEN_ZERO;
      cnt_q   <= CNT_ZERO;
      phase_q <= 3'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      l0_rd_q <= 1'b0;
      inst_q  <= {(3*row){1'b0}};
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      l0_rd_q <= l0_rd_d;
      inst_q  <= inst_d;
    end
  end

  assign inst_w = inst_q;
  assign l0_rd  = l0_rd_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign phase  = phase_q;

`ifdef CTRL_PERF_EN
  logic [31:0] run_q,  run_d;
  logic [31:0] perf_q, perf_d;

  // Busy-cycle counter; run_q holds the busy cycles seen before the current one.
  always_comb begin
    run_d  = run_q;
    perf_d = perf_q;
    if (state_q == S_IDLE) begin
      run_d = 32'd0;
    end else if (run_q != 32'hFFFF_FFFF) begin
      run_d = run_q + 32'd1;
    end else begin
      run_d = run_q;
    end
    // DONE itself is included, hence the +1 at capture.
    if (state_q == S_DONE) begin
      perf_d = (run_q == 32'hFFFF_FFFF) ? 32'hFFFF_FFFF : (run_q + 32'd1);
    end else begin
      perf_d = perf_q;
    end
  end

  // Performance registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      run_q  <= 32'd0;
      perf_q <= 32'd0;
    end else begin
      run_q  <= run_d;
      perf_q <= perf_d;
    end
  end

  assign perf_cycles = perf_q;
`endif

endmodule
